// File: rtl/icache_set_assoc.sv
// -----------------------------------------------------------------------------
// icache_set_assoc
//
// N-way set-associative instruction cache with multi-word lines and FIFO
// replacement. Sits between the IF stage and the memory controller. Lookups
// happen only in IDLE. A miss refills the whole line word by word, then the
// requested word is returned from a captured copy.
//
// Ports:
//   clk       clock
//   rst       asynchronous active-high reset
//   flush     invalidate all lines. Immediate in IDLE, otherwise deferred
//             until the return to IDLE.
//   if_req    fetch request. Held with if_addr until if_ready.
//   if_addr   word-aligned fetch address
//   if_ready  one-cycle pulse; if_inst valid
//   if_inst   returned instruction
//   mem_req   word read request to the memory controller
//   mem_addr  word address of the current refill read
//   mem_ack   one-cycle pulse; mem_data valid
//   mem_data  refill word
//   hit_cnt   accepted hits, wrapping
//   miss_cnt  accepted misses, wrapping
// -----------------------------------------------------------------------------
module icache_set_assoc #(
    parameter int ADDR_W     = 32,
    parameter int WAYS       = 2,
    parameter int SETS       = 128,
    parameter int LINE_WORDS = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              flush,
    input  logic              if_req,
    input  logic [ADDR_W-1:0] if_addr,
    output logic              if_ready,
    output logic [31:0]       if_inst,
    output logic              mem_req,
    output logic [ADDR_W-1:0] mem_addr,
    input  logic              mem_ack,
    input  logic [31:0]       mem_data,
    output logic [31:0]       hit_cnt,
    output logic [31:0]       miss_cnt
);

    localparam int IDX_W  = $clog2(SETS);
    localparam int OFF_W  = 2 + $clog2(LINE_WORDS);
    localparam int TAG_W  = ADDR_W - IDX_W - OFF_W;
    // Way and word selectors keep at least one bit so that the degenerate
    // configurations (WAYS=1, LINE_WORDS=1) still have legal indices.
    localparam int WAY_W  = (WAYS > 1) ? $clog2(WAYS) : 1;
    localparam int WORD_W = (LINE_WORDS > 1) ? $clog2(LINE_WORDS) : 1;

    typedef enum logic [1:0] {IDLE, REFILL, RESP} state_t;

    // Storage. Valid bits and FIFO pointers are flops because they need reset
    // and a single-cycle flush. Tags and data are plain arrays without reset.
    logic [WAYS-1:0]   valid_reg    [SETS];
    logic [WAY_W-1:0]  fifo_ptr_reg [SETS];
    logic [TAG_W-1:0]  tag_mem      [SETS][WAYS];
    logic [31:0]       data_mem     [SETS][WAYS][LINE_WORDS];

    state_t            state_reg;
    logic              flush_pend_reg;
    logic [IDX_W-1:0]  idx_reg;
    logic [TAG_W-1:0]  tag_reg;
    logic [WORD_W-1:0] word_reg;
    logic [WORD_W-1:0] cnt_reg;
    logic [WAY_W-1:0]  victim_reg;
    logic [31:0]       resp_word_reg;

    // Request address fields.
    logic [IDX_W-1:0]  req_idx;
    logic [TAG_W-1:0]  req_tag;
    logic [WORD_W-1:0] req_word;

    assign req_idx = if_addr[OFF_W+IDX_W-1:OFF_W];
    assign req_tag = if_addr[ADDR_W-1:OFF_W+IDX_W];

    generate
        if (LINE_WORDS > 1) begin : g_word_sel
            assign req_word = if_addr[OFF_W-1:2];
        end else begin : g_word_zero
            assign req_word = '0;
        end
    endgenerate

    // Parallel tag compare over all ways of the indexed set.
    logic [WAYS-1:0] way_hit;

    genvar gi;
    generate
        for (gi = 0; gi < WAYS; gi++) begin : g_way
            assign way_hit[gi] = valid_reg[req_idx][gi] &&
                                 (tag_mem[req_idx][gi] == req_tag);
        end
    endgenerate

    // A flush in the accept cycle forces a miss, and the victim is then
    // chosen as if the set were already empty.
    logic            hit;
    logic            accept;
    logic [WAYS-1:0] valid_eff;
    logic [31:0]     hit_data;
    logic [WAY_W-1:0] victim;
    logic            last_word;

    assign hit       = (|way_hit) && !flush;
    assign accept    = if_req && !if_ready;
    assign valid_eff = flush ? '0 : valid_reg[req_idx];
    assign last_word = (cnt_reg == WORD_W'(LINE_WORDS - 1));

    always_comb begin
        hit_data = '0;
        for (int w = 0; w < WAYS; w++) begin
            if (way_hit[WAY_W'(w)]) begin
                hit_data = hit_data | data_mem[req_idx][WAY_W'(w)][req_word];
            end
        end
    end

    // Lowest-index invalid way wins. Otherwise the FIFO pointer picks.
    always_comb begin
        victim = fifo_ptr_reg[req_idx];
        for (int w = WAYS - 1; w >= 0; w--) begin
            if (!valid_eff[WAY_W'(w)]) begin
                victim = WAY_W'(w);
            end
        end
    end

    // Control FSM with registered outputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg      <= IDLE;
            if_ready       <= 1'b0;
            if_inst        <= '0;
            mem_req        <= 1'b0;
            mem_addr       <= '0;
            hit_cnt        <= '0;
            miss_cnt       <= '0;
            flush_pend_reg <= 1'b0;
            idx_reg        <= '0;
            tag_reg        <= '0;
            word_reg       <= '0;
            cnt_reg        <= '0;
            victim_reg     <= '0;
            resp_word_reg  <= '0;
            for (int s = 0; s < SETS; s++) begin
                valid_reg[s]    <= '0;
                fifo_ptr_reg[s] <= '0;
            end
        end else begin
            if_ready <= 1'b0;
            case (state_reg)
                IDLE: begin
                    if (flush) begin
                        for (int s = 0; s < SETS; s++) begin
                            valid_reg[s] <= '0;
                        end
                    end
                    if (accept) begin
                        if (hit) begin
                            if_inst  <= hit_data;
                            if_ready <= 1'b1;
                            hit_cnt  <= hit_cnt + 32'd1;
                        end else begin
                            miss_cnt   <= miss_cnt + 32'd1;
                            idx_reg    <= req_idx;
                            tag_reg    <= req_tag;
                            word_reg   <= req_word;
                            victim_reg <= victim;
                            cnt_reg    <= '0;
                            mem_req    <= 1'b1;
                            mem_addr   <= {if_addr[ADDR_W-1:OFF_W], {OFF_W{1'b0}}};
                            state_reg  <= REFILL;
                        end
                    end
                end
                REFILL: begin
                    if (flush) begin
                        flush_pend_reg <= 1'b1;
                    end
                    if (mem_ack) begin
                        if (cnt_reg == word_reg) begin
                            resp_word_reg <= mem_data;
                        end
                        if (last_word) begin
                            valid_reg[idx_reg][victim_reg] <= 1'b1;
                            // Filling an invalid way that is not the FIFO head
                            // leaves the replacement order untouched.
                            if ((WAYS > 1) && (victim_reg == fifo_ptr_reg[idx_reg])) begin
                                fifo_ptr_reg[idx_reg] <= fifo_ptr_reg[idx_reg] + 1'b1;
                            end
                            mem_req   <= 1'b0;
                            state_reg <= RESP;
                        end else begin
                            cnt_reg  <= cnt_reg + 1'b1;
                            mem_addr <= mem_addr + ADDR_W'(4);
                        end
                    end
                end
                RESP: begin
                    if_inst   <= resp_word_reg;
                    if_ready  <= 1'b1;
                    state_reg <= IDLE;
                    // A deferred flush lands on the way back to IDLE. It
                    // therefore also invalidates the line that was just filled.
                    if (flush || flush_pend_reg) begin
                        for (int s = 0; s < SETS; s++) begin
                            valid_reg[s] <= '0;
                        end
                    end
                    flush_pend_reg <= 1'b0;
                end
                default: begin
                    state_reg <= IDLE;
                end
            endcase
        end
    end

    // Line storage writes. Each refill word goes straight into the victim way.
    // The tag is written together with the final word.
    always_ff @(posedge clk) begin
        if ((state_reg == REFILL) && mem_ack) begin
            data_mem[idx_reg][victim_reg][cnt_reg] <= mem_data;
            if (last_word) begin
                tag_mem[idx_reg][victim_reg] <= tag_reg;
            end
        end
    end

endmodule

// File: tb/tb_icache_set_assoc.sv
// -----------------------------------------------------------------------------
// tb_icache_set_assoc
//
// Directed testbench for icache_set_assoc with ADDR_W=18, WAYS=2, SETS=4 and
// LINE_WORDS=2. A behavioural memory answers each refill read three cycles
// after mem_req is first seen, returning the read address as data.
// Addresses 0x10, 0x30 and 0x50 all map to set 2.
// -----------------------------------------------------------------------------
module tb_icache_set_assoc;

    logic        clk;
    logic        rst;
    logic        flush;
    logic        if_req;
    logic [17:0] if_addr;
    logic        if_ready;
    logic [31:0] if_inst;
    logic        mem_req;
    logic [17:0] mem_addr;
    logic        mem_ack;
    logic [31:0] mem_data;
    logic [31:0] hit_cnt;
    logic [31:0] miss_cnt;

    icache_set_assoc #(
        .ADDR_W    (18),
        .WAYS      (2),
        .SETS      (4),
        .LINE_WORDS(2)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .flush    (flush),
        .if_req   (if_req),
        .if_addr  (if_addr),
        .if_ready (if_ready),
        .if_inst  (if_inst),
        .mem_req  (mem_req),
        .mem_addr (mem_addr),
        .mem_ack  (mem_ack),
        .mem_data (mem_data),
        .hit_cnt  (hit_cnt),
        .miss_cnt (miss_cnt)
    );

    int errors = 0;
    int checks = 0;
    int cyc = 0;

    // Memory-model bookkeeping, written only by the memory process.
    int          lat = 0;
    int          ack_cnt = 0;
    int          req_cycles = 0;
    int          last_ack_cyc = 0;
    int          stray_done = 0;
    logic [17:0] ack_addrs [$];

    // Written only by the main sequence.
    int stray_req = 0;
    int fetch_base = 0;

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        forever begin
            @(posedge clk);
            cyc++;
        end
    end

    // Memory: acks three cycles after mem_req is first seen, data = address.
    // A stray request pulses mem_ack with junk while no read is outstanding.
    initial begin
        mem_ack  = 1'b0;
        mem_data = '0;
        forever begin
            @(negedge clk);
            mem_ack = 1'b0;
            if (rst) begin
                lat = 0;
            end else if (stray_done != stray_req) begin
                stray_done = stray_req;
                mem_ack    = 1'b1;
                mem_data   = 32'hDEAD_BEEF;
            end else if (mem_req) begin
                req_cycles++;
                if (lat == 2) begin
                    mem_ack  = 1'b1;
                    mem_data = {14'h0, mem_addr};
                    lat      = 0;
                    ack_cnt++;
                    ack_addrs.push_back(mem_addr);
                    last_ack_cyc = cyc;
                end else begin
                    lat++;
                end
            end else begin
                lat = 0;
            end
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    // One fetch, starting at negedge+1 with the cache idle.
    // flush_mode 0: no flush. 1: flush in the accept cycle.
    // 2: flush together with the first refill ack.
    task automatic fetch(input logic [17:0] addr, input logic [31:0] exp_inst,
                         input bit exp_hit, input int flush_mode, input string tag);
        int start_cyc;
        int start_acks;
        int start_reqs;
        int ready_cyc;
        int n;
        bit got;
        bit flushed;
        start_cyc  = cyc;
        start_acks = ack_cnt;
        start_reqs = req_cycles;
        fetch_base = ack_addrs.size();
        if_addr    = addr;
        if_req     = 1'b1;
        if (flush_mode == 1) flush = 1'b1;
        got       = 1'b0;
        flushed   = 1'b0;
        n         = 0;
        ready_cyc = 0;
        while (!got && n < 100) begin
            @(negedge clk);
            #1;
            n++;
            flush = 1'b0;
            if (flush_mode == 2 && !flushed && (ack_cnt - start_acks) == 1) begin
                flush   = 1'b1;
                flushed = 1'b1;
            end
            if (if_ready) begin
                got       = 1'b1;
                ready_cyc = cyc;
            end
        end
        flush = 1'b0;
        check({tag, ":ready_seen"}, 32'(got), 32'd1);
        check({tag, ":inst"}, if_inst, exp_inst);
        if (exp_hit) begin
            check({tag, ":hit_latency"}, 32'(ready_cyc - start_cyc), 32'd1);
            check({tag, ":no_mem_req"}, 32'(req_cycles - start_reqs), 32'd0);
        end else begin
            check({tag, ":refill_acks"}, 32'(ack_cnt - start_acks), 32'd2);
            check({tag, ":ack_to_ready"}, 32'(ready_cyc - last_ack_cyc), 32'd2);
        end
        // Keep if_req high over one more edge; the cache must not accept it again.
        @(negedge clk);
        #1;
        check({tag, ":ready_pulse"}, 32'(if_ready), 32'd0);
        if_req = 1'b0;
        $display("fetch %s addr=0x%05h inst=0x%08h hit_cnt=%0d miss_cnt=%0d",
                 tag, addr, if_inst, hit_cnt, miss_cnt);
    endtask

    initial begin
        int n;
        rst     = 1'b1;
        flush   = 1'b0;
        if_req  = 1'b0;
        if_addr = '0;

        // Reset state.
        @(negedge clk);
        @(negedge clk);
        #1;
        check("reset:if_ready", 32'(if_ready), 32'd0);
        check("reset:if_inst", if_inst, 32'd0);
        check("reset:mem_req", 32'(mem_req), 32'd0);
        check("reset:mem_addr", 32'(mem_addr), 32'd0);
        check("reset:hit_cnt", hit_cnt, 32'd0);
        check("reset:miss_cnt", miss_cnt, 32'd0);
        rst = 1'b0;
        @(negedge clk);
        #1;

        // Cold miss, then hits on both words of the line.
        fetch(18'h00010, 32'h10, 1'b0, 0, "cold_0x10");
        check("cold:read0", 32'(ack_addrs[fetch_base]), 32'h10);
        check("cold:read1", 32'(ack_addrs[fetch_base + 1]), 32'h14);
        check("cold:miss_cnt", miss_cnt, 32'd1);
        fetch(18'h00010, 32'h10, 1'b1, 0, "hit_0x10");
        check("hit:hit_cnt", hit_cnt, 32'd1);
        fetch(18'h00014, 32'h14, 1'b1, 0, "hit_0x14");
        check("hit2:hit_cnt", hit_cnt, 32'd2);

        // FIFO eviction in set 2.
        fetch(18'h00030, 32'h30, 1'b0, 0, "fill_0x30");
        fetch(18'h00050, 32'h50, 1'b0, 0, "fill_0x50_evicts_0x10");
        fetch(18'h00030, 32'h30, 1'b1, 0, "hit_0x30");
        fetch(18'h00010, 32'h10, 1'b0, 0, "miss_0x10_evicts_0x30");
        fetch(18'h00050, 32'h50, 1'b1, 0, "hit_0x50");
        fetch(18'h00030, 32'h30, 1'b0, 0, "miss_0x30_evicts_0x50");
        fetch(18'h00010, 32'h10, 1'b1, 0, "hit_0x10_kept");
        check("fifo:hit_cnt", hit_cnt, 32'd5);
        check("fifo:miss_cnt", miss_cnt, 32'd5);

        // Full tag: bit 17 alone must distinguish the lines.
        fetch(18'h20010, 32'h20010, 1'b0, 0, "fulltag_0x20010");
        check("fulltag:read0", 32'(ack_addrs[fetch_base]), 32'h20010);
        fetch(18'h20010, 32'h20010, 1'b1, 0, "fulltag_hit");

        // Flush in IDLE with 0x10 and 0x30 cached.
        fetch(18'h00010, 32'h10, 1'b0, 0, "refill_0x10");
        fetch(18'h00030, 32'h30, 1'b0, 0, "refill_0x30");
        fetch(18'h00030, 32'h30, 1'b1, 0, "hit_0x30_preflush");
        flush = 1'b1;
        @(negedge clk);
        #1;
        flush = 1'b0;
        @(negedge clk);
        #1;
        fetch(18'h00030, 32'h30, 1'b0, 0, "miss_0x30_postflush");
        check("flush:miss_cnt", miss_cnt, 32'd9);

        // Flush in the accept cycle forces a miss on a cached line.
        fetch(18'h00030, 32'h30, 1'b0, 1, "flush_at_accept");
        check("flushacc:miss_cnt", miss_cnt, 32'd10);
        fetch(18'h00030, 32'h30, 1'b1, 0, "hit_after_flushacc");

        // Flush between the two refill acks: data still returned, line dropped.
        fetch(18'h00010, 32'h10, 1'b0, 2, "flush_in_refill");
        fetch(18'h00010, 32'h10, 1'b0, 0, "miss_after_pending_flush");
        check("pend:hit_cnt", hit_cnt, 32'd8);
        check("pend:miss_cnt", miss_cnt, 32'd12);

        // Reset in the middle of a refill.
        if_addr = 18'h00050;
        if_req  = 1'b1;
        n = 0;
        while (!mem_req && n < 20) begin
            @(negedge clk);
            #1;
            n++;
        end
        check("rst:reached_refill", 32'(mem_req), 32'd1);
        rst = 1'b1;
        #1;
        check("rst:mem_req", 32'(mem_req), 32'd0);
        check("rst:if_ready", 32'(if_ready), 32'd0);
        check("rst:mem_addr", 32'(mem_addr), 32'd0);
        check("rst:hit_cnt", hit_cnt, 32'd0);
        check("rst:miss_cnt", miss_cnt, 32'd0);
        if_req = 1'b0;
        @(negedge clk);
        #1;
        @(negedge clk);
        #1;
        rst = 1'b0;
        stray_req++;
        @(negedge clk);
        #1;
        @(negedge clk);
        #1;
        check("stray:mem_req", 32'(mem_req), 32'd0);
        fetch(18'h00010, 32'h10, 1'b0, 0, "after_reset_0x10");
        check("after_rst:miss_cnt", miss_cnt, 32'd1);
        check("after_rst:hit_cnt", hit_cnt, 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
